// File: rtl/circle_crop_ctrl.sv
// circle_crop_ctrl: frame-synchronous controller for circle_crop.
// Committed crop settings sit in shadow registers and take effect only at the next frame start.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif

module circle_crop_ctrl #(
   parameter int unsigned DIM_WIDTH = 12,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic                    dvi,
   input  logic [`DTYPE_WIDTH-1:0] dtypei,
   input  logic                    cfg_enable,
   input  logic [DIM_WIDTH-1:0]    cfg_overage,
   input  logic [CNT_WIDTH-1:0]    cfg_frames,
   input  logic                    cfg_commit,
   input  logic                    cfg_abort,
   output logic                    enable,
   output logic [DIM_WIDTH-1:0]    overage,
   output logic                    pending,
   output logic                    busy,
   output logic                    in_frame,
   output logic [CNT_WIDTH-1:0]    frames_done
);

   localparam int unsigned DTW = `DTYPE_WIDTH;
   localparam logic [DTW-1:0] DT_SOF = DTW'(`DTYPE_FRAME_START);
   localparam logic [DTW-1:0] DT_EOF = DTW'(`DTYPE_FRAME_END);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic                   enable_q, enable_d;
   logic [DIM_WIDTH-1:0]   overage_q, overage_d;
   logic                   pending_q, pending_d;
   logic                   busy_q, busy_d;
   logic                   in_frame_q, in_frame_d;
   logic [CNT_WIDTH-1:0]   frames_done_q, frames_done_d;
   logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
   logic                   stop_req_q, stop_req_d;
   logic                   sh_enable_q, sh_enable_d;
   logic [DIM_WIDTH-1:0]   sh_overage_q, sh_overage_d;
   logic [CNT_WIDTH-1:0]   sh_frames_q, sh_frames_d;

   logic sof_c;
   logic eof_c;
   logic apply_c;
   logic stop_now_c;

   assign sof_c = dvi && (dtypei == DT_SOF);
   assign eof_c = dvi && (dtypei == DT_EOF);

   // abort blocks an apply on the same sof; pending is judged before this cycle's commit
   assign apply_c    = sof_c && pending_q && !cfg_abort;
   assign stop_now_c = (cfg_abort && (!in_frame_q || sof_c || eof_c)) ||
                       (stop_req_q && eof_c);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q       <= ST_IDLE;
         enable_q      <= 1'b0;
         overage_q     <= '0;
         pending_q     <= 1'b0;
         busy_q        <= 1'b0;
         in_frame_q    <= 1'b0;
         frames_done_q <= '0;
         remaining_q   <= '0;
         stop_req_q    <= 1'b0;
         sh_enable_q   <= 1'b0;
         sh_overage_q  <= '0;
         sh_frames_q   <= '0;
      end else begin
         state_q       <= state_d;
         enable_q      <= enable_d;
         overage_q     <= overage_d;
         pending_q     <= pending_d;
         busy_q        <= busy_d;
         in_frame_q    <= in_frame_d;
         frames_done_q <= frames_done_d;
         remaining_q   <= remaining_d;
         stop_req_q    <= stop_req_d;
         sh_enable_q   <= sh_enable_d;
         sh_overage_q  <= sh_overage_d;
         sh_frames_q   <= sh_frames_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      enable_d      = enable_q;
      overage_d     = overage_q;
      pending_d     = pending_q;
      in_frame_d    = in_frame_q;
      frames_done_d = frames_done_q;
      remaining_d   = remaining_q;
      stop_req_d    = stop_req_q;
      sh_enable_d   = sh_enable_q;
      sh_overage_d  = sh_overage_q;
      sh_frames_d   = sh_frames_q;

      if (sof_c) begin
         in_frame_d = 1'b1;
      end else if (eof_c) begin
         in_frame_d = 1'b0;
      end

      // frame completion; a nonzero budget counts down and stops at zero
      if (eof_c && (state_q == ST_RUN)) begin
         if (frames_done_q != CNT_MAX) begin
            frames_done_d = frames_done_q + CNT_ONE;
         end
         if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
               enable_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
      end

      if (apply_c) begin
         enable_d      = sh_enable_q;
         overage_d     = sh_overage_q;
         remaining_d   = sh_frames_q;
         frames_done_d = '0;
         stop_req_d    = 1'b0;
         state_d       = sh_enable_q ? ST_RUN : ST_IDLE;
      end else if (stop_now_c) begin
         enable_d = 1'b0;
         state_d  = ST_IDLE;
      end

      if (apply_c || cfg_abort) begin
         pending_d = 1'b0;
      end
      if (cfg_commit) begin
         pending_d    = 1'b1;
         sh_enable_d  = cfg_enable;
         sh_overage_d = cfg_overage;
         sh_frames_d  = cfg_frames;
      end

      if (cfg_abort && !stop_now_c) begin
         stop_req_d = 1'b1;
      end
      if (state_d == ST_IDLE) begin
         stop_req_d = 1'b0;
      end

      busy_d = (state_d == ST_RUN);
   end

   assign enable      = enable_q;
   assign overage     = overage_q;
   assign pending     = pending_q;
   assign busy        = busy_q;
   assign in_frame    = in_frame_q;
   assign frames_done = frames_done_q;

endmodule

// File: doc/circle_crop_ctrl.md
# circle_crop_ctrl

Frame-synchronous controller for the `circle_crop` datapath. Software writes a crop configuration (enable, overage, frame count) through DI terminal registers and issues a commit. The block holds it in shadow registers and applies it only at the next frame start seen on the pixel stream, so a frame is never cropped with mixed settings. It also runs crop for a programmed number of frames, then stops cleanly at a frame boundary, and supports a frame-aligned abort.

## Interface
Parameters:
- DIM_WIDTH, 12, width of overage value (matches `circle_crop` DIM_WIDTH)
- CNT_WIDTH, 16, width of frame count / frames_done

Ports:
- clk  in  1  pixel clock (same clock as `circle_crop`)
- resetb  in  1  asynchronous, active-low reset
- dvi  in  1  data valid of the stream entering `circle_crop`
- dtypei  in  `DTYPE_WIDTH`  dtype of that stream; only `DTYPE_FRAME_START` / `DTYPE_FRAME_END` (dtypes.v) are decoded
- cfg_enable  in  1  requested crop enable
- cfg_overage  in  DIM_WIDTH  requested overage
- cfg_frames  in  CNT_WIDTH  frames to crop; 0 = continuous
- cfg_commit  in  1  single-cycle pulse: capture cfg_* into shadow
- cfg_abort  in  1  single-cycle pulse: stop cropping at the next frame boundary
- enable  out  1  to `circle_crop.enable`, registered
- overage  out  DIM_WIDTH  to `circle_crop.overage`, registered
- pending  out  1  shadow holds an unapplied commit
- busy  out  1  state is RUN
- in_frame  out  1  between frame start and frame end
- frames_done  out  CNT_WIDTH  frames completed since the last apply, saturating

## Operation
- Events: sof = dvi && dtypei==`DTYPE_FRAME_START`; eof = dvi && dtypei==`DTYPE_FRAME_END`.
- in_frame: set the cycle after sof, cleared the cycle after eof. sof while in_frame (missing eof) re-sets it and is still treated as a frame start.
- Commit: cfg_commit loads sh_enable, sh_overage, sh_frames and sets pending. Repeated commits before sof overwrite the shadow (last wins).
- States: IDLE (enable=0) and RUN (enable=active value).
- Apply, at sof with pending set (pending sampled before this cycle's commit):
  - copy the shadow to enable/overage;
  - remaining ← sh_frames, frames_done ← 0, clear pending;
  - next state RUN if sh_enable=1, else IDLE.
  - Applies from either state.
- Frame completion, at eof in RUN:
  - frames_done increments, saturating at all-ones.
  - If remaining≠0: remaining decrements. On reaching 0, enable ← 0 and go to IDLE. overage holds its value.
  - If remaining=0 at apply (continuous): no decrement, run forever.
- Abort: cfg_abort sets stop_req and clears pending.
  - Not in_frame: enable ← 0, go to IDLE on the next cycle.
  - in_frame: go to IDLE at the next eof.
  - stop_req clears on entering IDLE.
  - A commit after the abort sets pending again and applies at the following sof.
- Same-cycle events:
  - commit with sof: the shadow updates, and the older pending (if any) is applied. If no pending existed before, the new commit waits for the next sof.
  - abort with sof: abort wins; no apply, go to IDLE.
  - abort with eof: go to IDLE.
  - commit with abort: abort clears the old pending, and the commit then sets pending with its own values.
- Width rules:
  - overage passes through unmodified at DIM_WIDTH.
  - remaining and frames_done are CNT_WIDTH unsigned; no wrap.

## Timing
- Reset values: enable=0, overage=0, pending=0, busy=0, in_frame=0, frames_done=0. Shadow, remaining and stop_req are 0; state IDLE.
- All outputs are registered.
- Apply latency: enable/overage change on the cycle after the sof cycle. `circle_crop` sees the new values before the first row pixel because sof carries no pixel.
- Count stop: enable falls the cycle after the final eof.
- pending asserts the cycle after commit and drops the cycle after the applying sof.
- No back-pressure: events are single-cycle qualified by dvi, and every cycle is processed.
- Reset asserted mid-frame returns immediately to the reset values. The first sof after reset applies nothing unless a commit occurred.

## Test plan
- Commit (en=1, ov=40, frames=0) mid-frame → enable stays 0 until the next sof, then enable=1 and overage=40 one cycle later; it stays on across 5 frames, with frames_done=5.
- Commit (en=1, frames=3), run 4 frames → enable=1 for frames 1–3 only, falls the cycle after the 3rd eof, busy=0, frames_done=3.
- Two commits (ov=10, then ov=20) before sof → overage=20 applied, pending=0 after sof.
- Abort mid-frame in RUN → enable holds through the frame, drops the cycle after eof. Abort between frames → drops the next cycle.
- Commit coincident with sof, no prior pending → no change this frame; applied at the following sof.
- resetb pulsed low mid-frame with enable=1 → all outputs 0 immediately. The next sof without a commit leaves enable=0.
